// File: rtl/ihp_sram_arbiter.sv
// Two-port request arbiter in front of a single-port 1024x32 SRAM macro.
// Optionally zero-fills the macro after fabric configuration, then serves A/B requests.
module ihp_sram_arbiter #(
  parameter int CLEAR_ON_START = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        UserCLK,
  input  logic        RST,
  input  logic        CONFIGURED,

  input  logic        A_VALID,
  output logic        A_READY,
  input  logic        A_WE,
  input  logic [9:0]  A_ADDR,
  input  logic [31:0] A_DIN,
  input  logic [31:0] A_BM,
  output logic [31:0] A_RDATA,
  output logic        A_RVALID,

  input  logic        B_VALID,
  output logic        B_READY,
  input  logic        B_WE,
  input  logic [9:0]  B_ADDR,
  input  logic [31:0] B_DIN,
  input  logic [31:0] B_BM,
  output logic [31:0] B_RDATA,
  output logic        B_RVALID,

  output logic [9:0]  ADDR_SRAM,
  output logic [31:0] DIN_SRAM,
  output logic [31:0] BM_SRAM,
  output logic        WEN_SRAM,
  output logic        MEN_SRAM,
  output logic        REN_SRAM,
  input  logic [31:0] DOUT_SRAM,

  output logic        BUSY
);

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    CLEAR    = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t      state;
  logic [9:0]  clr_cnt;
  logic        last_grant;   // 1 = B was granted last
  logic        pend_valid;   // read issued last cycle, data appears on DOUT_SRAM now
  logic        pend_port;    // 1 = that read belongs to B

  logic        serving;
  logic        clearing;
  logic        grant_a;
  logic        grant_b;
  logic        rd_issue;

  always_comb begin
    serving  = (state == RUN) && CONFIGURED && !RST;
    clearing = (state == CLEAR) && CONFIGURED && !RST;

    // A wins unless B also asks and round-robin says it is B's turn.
    grant_a  = A_VALID && (!B_VALID || (FIXED_PRIORITY != 0) || last_grant);
    grant_b  = B_VALID && !grant_a;

    A_READY  = serving && grant_a;
    B_READY  = serving && grant_b;
    rd_issue = (A_READY && !A_WE) || (B_READY && !B_WE);
    BUSY     = (state != RUN) || RST;

    ADDR_SRAM = '0;
    DIN_SRAM  = '0;
    BM_SRAM   = '0;
    WEN_SRAM  = 1'b0;
    MEN_SRAM  = 1'b0;
    REN_SRAM  = 1'b0;
    if (clearing) begin
      ADDR_SRAM = clr_cnt;
      BM_SRAM   = '1;
      WEN_SRAM  = 1'b1;
      MEN_SRAM  = 1'b1;
    end else if (A_READY) begin
      ADDR_SRAM = A_ADDR;
      DIN_SRAM  = A_DIN;
      BM_SRAM   = A_BM;
      WEN_SRAM  = A_WE;
      REN_SRAM  = !A_WE;
      MEN_SRAM  = 1'b1;
    end else if (B_READY) begin
      ADDR_SRAM = B_ADDR;
      DIN_SRAM  = B_DIN;
      BM_SRAM   = B_BM;
      WEN_SRAM  = B_WE;
      REN_SRAM  = !B_WE;
      MEN_SRAM  = 1'b1;
    end
  end

  always_ff @(posedge UserCLK) begin
    if (RST) begin
      state      <= WAIT_CFG;
      clr_cnt    <= '0;
      last_grant <= 1'b1;
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      A_RDATA    <= '0;
      B_RDATA    <= '0;
      A_RVALID   <= 1'b0;
      B_RVALID   <= 1'b0;
    end else begin
      case (state)
        WAIT_CFG: begin
          clr_cnt <= '0;
          if (CONFIGURED) state <= (CLEAR_ON_START != 0) ? CLEAR : RUN;
        end
        CLEAR: begin
          if (!CONFIGURED) begin
            state   <= WAIT_CFG;
            clr_cnt <= '0;
          end else if (clr_cnt == 10'd1023) begin
            state   <= RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 10'd1;
          end
        end
        RUN: begin
          if (!CONFIGURED) state <= WAIT_CFG;
        end
        default: state <= WAIT_CFG;
      endcase

      if (A_READY || B_READY) last_grant <= B_READY;

      // Read return pipeline keeps running even if CONFIGURED drops.
      pend_valid <= rd_issue;
      pend_port  <= B_READY;
      A_RVALID   <= pend_valid && !pend_port;
      B_RVALID   <= pend_valid && pend_port;
      if (pend_valid && !pend_port) A_RDATA <= DOUT_SRAM;
      if (pend_valid && pend_port)  B_RDATA <= DOUT_SRAM;
    end
  end

endmodule
